mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 135 +++++++++++++
 tb/tb_mul_div_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 16-bit multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_SIGNED_EN to add the sgn port and two's-complement operation.
module mul_div_unit #(
    parameter logic [15:0] DZ_QUOTIENT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
`ifdef MDU_SIGNED_EN
    input  logic        sgn,
`endif
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [3:0]  dest,
    output logic        busy,
    output logic        done,
    output logic [1:0]  RegWrite,
    output logic [3:0]  WriteReg,
    output logic [15:0] WriteData,
    output logic [15:0] WriteR15,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        op_q;
    logic        neg_q;
    logic        rneg_q;
    logic [3:0]  dest_q;
    logic [31:0] acc;
    logic [15:0] bop;

    logic        sgn_eff;
    logic [15:0] abs_a;
    logic [15:0] abs_b;
    logic [16:0] mul_sum;
    logic [16:0] div_trial;
    logic [31:0] acc_nx;
    logic [31:0] prod;
    logic [15:0] quo;
    logic [15:0] rem;

`ifdef MDU_SIGNED_EN
    assign sgn_eff = sgn;
`else
    assign sgn_eff = 1'b0;
`endif

    // Signed operation runs on magnitudes; the result signs are fixed up on the last step.
    always_comb begin
        abs_a     = (sgn_eff && opA[15]) ? -opA : opA;
        abs_b     = (sgn_eff && opB[15]) ? -opB : opB;
        mul_sum   = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, bop} : 17'd0);
        div_trial = acc[31:15] - {1'b0, bop};
        if (op_q) begin
            acc_nx = div_trial[16] ? {acc[30:0], 1'b0} : {div_trial[15:0], acc[14:0], 1'b1};
        end else begin
            acc_nx = {mul_sum, acc[15:1]};
        end
        prod = neg_q ? -acc_nx : acc_nx;
        quo  = neg_q ? -acc_nx[15:0] : acc_nx[15:0];
        rem  = rneg_q ? -acc_nx[31:16] : acc_nx[31:16];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_q      <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dest_q    <= 4'd0;
            acc       <= 32'd0;
            bop       <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            RegWrite  <= 2'b00;
            WriteReg  <= 4'd0;
            WriteData <= 16'd0;
            WriteR15  <= 16'd0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op && opB == 16'd0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            RegWrite  <= 2'b10;
                            WriteReg  <= dest;
                            WriteData <= DZ_QUOTIENT;
                            WriteR15  <= opA;
                            div_zero  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            cnt    <= 4'd0;
                            op_q   <= op;
                            dest_q <= dest;
                            neg_q  <= sgn_eff && (opA[15] ^ opB[15]);
                            rneg_q <= sgn_eff && opA[15];
                            // Multiply keeps the multiplier in the low half; divide the dividend.
                            acc    <= op ? {16'd0, abs_a} : {16'd0, abs_b};
                            bop    <= op ? abs_b : abs_a;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        RegWrite  <= 2'b10;
                        WriteReg  <= dest_q;
                        WriteData <= op_q ? quo : prod[15:0];
                        WriteR15  <= op_q ? rem : prod[31:16];
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    RegWrite <= 2'b00;
                    div_zero <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; honours MDU_SIGNED_EN like the design.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic        sgn;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [3:0]  dest;
    logic        busy;
    logic        done;
    logic [1:0]  RegWrite;
    logic [3:0]  WriteReg;
    logic [15:0] WriteData;
    logic [15:0] WriteR15;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.DZ_QUOTIENT(16'hFFFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
`ifdef MDU_SIGNED_EN
        .sgn      (sgn),
`endif
        .opA      (opA),
        .opB      (opB),
        .dest     (dest),
        .busy     (busy),
        .done     (done),
        .RegWrite (RegWrite),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .WriteR15 (WriteR15),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (lat = cycles after start).
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [3:0] d, input int restart_at,
                          output int lat, output int busy_cnt);
        start = 1'b1; op = o; opA = a; opB = b; sgn = s; dest = d;
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; op = ~o; opA = 16'($urandom); opB = 16'($urandom);
                sgn = ~s; dest = ~d;
            end
            if (restart_at != 0 && i == restart_at) begin
                start = 1'b1; op = 1'b0; opA = 16'h0102; opB = 16'h0009;
            end
            if (restart_at != 0 && i == restart_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic result(input string tag, input int lat, input int busy_cnt,
                          input int exp_lat, input logic [3:0] wr, input logic [15:0] wd,
                          input logic [15:0] r15, input logic dz);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        chk({tag, "_regwrite"}, {30'd0, RegWrite}, 32'd2);
        chk({tag, "_writereg"}, {28'd0, WriteReg}, {28'd0, wr});
        chk({tag, "_writedata"}, {16'd0, WriteData}, {16'd0, wd});
        chk({tag, "_writer15"}, {16'd0, WriteR15}, {16'd0, r15});
        chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, dz});
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        chk({tag, "_regwrite_idle"}, {30'd0, RegWrite}, 32'd0);
        chk({tag, "_hold_data"}, {WriteR15, WriteData}, {r15, wd});
    endtask

    initial begin
        int lat;
        int bc;
        int seen_done;
        int seen_wr;

        rst = 1'b0; start = 1'b1; op = 1'b0; sgn = 1'b0;
        opA = 16'hAAAA; opB = 16'h5555; dest = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst_regwrite", {30'd0, RegWrite}, 32'd0);
        chk("rst_outputs", {12'd0, WriteReg, WriteData}, 32'd0);
        chk("rst_r15", {16'd0, WriteR15}, 32'd0);

        // Start accepted on the first edge with rst high.
        rst = 1'b1;
        run_op(1'b0, 16'h7B18, 16'h245B, 1'b0, 4'd4, 0, lat, bc);
        result("mul_u", lat, bc, 17, 4'd4, 16'h2188, 16'h117B, 1'b0);

        run_op(1'b1, 16'h6666, 16'h0051, 1'b0, 4'd7, 0, lat, bc);
        result("div_u", lat, bc, 17, 4'd7, 16'h0143, 16'h0033, 1'b0);

        run_op(1'b1, 16'h3099, 16'h0000, 1'b0, 4'd9, 0, lat, bc);
        result("div_zero", lat, bc, 1, 4'd9, 16'hFFFF, 16'h3099, 1'b1);

        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 4'd1, 0, lat, bc);
        result("mul_max", lat, bc, 17, 4'd1, 16'h0001, 16'hFFFE, 1'b0);

        // Second start during RUN is ignored.
        run_op(1'b0, 16'h0003, 16'h0005, 1'b0, 4'd2, 5, lat, bc);
        result("busy_reject", lat, bc, 17, 4'd2, 16'h000F, 16'h0000, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("busy_reject_no_queue", seen_done, 0);

        // Reset mid-operation aborts it.
        start = 1'b1; op = 1'b0; opA = 16'h1234; opB = 16'h0021; dest = 4'd3; sgn = 1'b0;
        seen_done = 0;
        seen_wr = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) seen_done++;
            if (RegWrite != 2'b00) seen_wr++;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cleared", {WriteR15, WriteData}, 32'd0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (RegWrite != 2'b00) seen_wr++;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_no_regwrite", seen_wr, 0);

        run_op(1'b0, 16'h0100, 16'h0100, 1'b0, 4'd5, 0, lat, bc);
        result("after_abort", lat, bc, 17, 4'd5, 16'h0000, 16'h0001, 1'b0);

`ifdef MDU_SIGNED_EN
        run_op(1'b0, 16'hFFFE, 16'h0003, 1'b1, 4'd6, 0, lat, bc);
        result("mul_s", lat, bc, 17, 4'd6, 16'hFFFA, 16'hFFFF, 1'b0);
        run_op(1'b1, 16'hFFF9, 16'h0002, 1'b1, 4'd8, 0, lat, bc);
        result("div_s", lat, bc, 17, 4'd8, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op(1'b1, 16'h8000, 16'hFFFF, 1'b1, 4'd10, 0, lat, bc);
        result("div_s_ovf", lat, bc, 17, 4'd10, 16'h8000, 16'h0000, 1'b0);
        run_op(1'b1, 16'hFFFB, 16'h0000, 1'b1, 4'd11, 0, lat, bc);
        result("div_s_zero", lat, bc, 1, 4'd11, 16'hFFFF, 16'hFFFB, 1'b1);
        run_op(1'b0, 16'hFFFE, 16'h0003, 1'b0, 4'd12, 0, lat, bc);
        result("mul_sgn0", lat, bc, 17, 4'd12, 16'hFFFA, 16'h0002, 1'b0);
`else
        run_op(1'b0, 16'hFFFE, 16'h0003, 1'b1, 4'd6, 0, lat, bc);
        result("mul_unsigned_only", lat, bc, 17, 4'd6, 16'hFFFA, 16'h0002, 1'b0);
        run_op(1'b1, 16'hFFF9, 16'h0002, 1'b1, 4'd8, 0, lat, bc);
        result("div_unsigned_only", lat, bc, 17, 4'd8, 16'h7FFC, 16'h0001, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
